dfh_mmio_router: RTL and testbench
==================================

# dfh_mmio_router

Fan-out stage between the host MMIO Avalon-MM port and a row of DFH CSR slaves (one 64-bit-register feature per slave). It decodes the host byte address into a slave index, forwards reads and writes as registered single-cycle pulses, and enforces one outstanding read. It returns slave read data to the host in order. Unmapped and timed-out reads are answered with a fixed bad-address pattern, so the host never hangs.

## Interface
Parameters:
- N_SLAVES, 4, number of CSR slaves (1..16)
- SLAVE_SPAN_LOG2, 12, log2 of byte window per slave (4 KB DFH-aligned)
- ADDR_WIDTH, 16, host byte-address width
- TIMEOUT_CYCLES, 256, cycles to wait for slave readdatavalid (>=2)
- BADADDR_DATA, 64'hBAAD_BAAD_BAAD_BAAD, read data for unmapped or timed-out reads

Ports (clock and reset first):
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- h_address  in  ADDR_WIDTH  host byte address
- h_read  in  1  host read request
- h_write  in  1  host write request
- h_writedata  in  64  write data
- h_byteenable  in  8  byte enables, passed through
- h_waitrequest  out  1  high = request not accepted
- h_readdata  out  64  read response data
- h_readdatavalid  out  1  one-cycle read response strobe
- s_address  out  N_SLAVES*SLAVE_SPAN_LOG2  per-slave byte offset, slice i for slave i
- s_read  out  N_SLAVES  per-slave read pulse
- s_write  out  N_SLAVES  per-slave write pulse
- s_writedata  out  64  shared write data
- s_byteenable  out  8  shared byte enables
- s_readdata  in  N_SLAVES*64  per-slave read data
- s_readdatavalid  in  N_SLAVES  per-slave response strobe
- timeout_err  out  1  sticky flag: a read timed out
- stray_err  out  1  sticky flag: an unexpected s_readdatavalid arrived

## Operation
- Decode: idx = h_address[ADDR_WIDTH-1:SLAVE_SPAN_LOG2]; offset = h_address[SLAVE_SPAN_LOG2-1:0]. A request is mapped iff idx < N_SLAVES.
- FSM states:
  - IDLE: h_waitrequest = 0.
  - RD_WAIT: h_waitrequest = 1. A slave read is outstanding.
  - RD_BAD: h_waitrequest = 1. An unmapped read is being answered.
- h_waitrequest = reset OR (state != IDLE), combinational.
- In IDLE:
  - Mapped read: register sel = idx. Next cycle s_read[sel] = 1 for exactly one cycle and s_address slice sel = offset. Clear timer; go to RD_WAIT.
  - Unmapped read: go to RD_BAD. Next cycle h_readdatavalid = 1 and h_readdata = BADADDR_DATA; return to IDLE.
  - Mapped write: next cycle s_write[idx] = 1 for one cycle with registered writedata, byteenable and offset. Stay in IDLE, so back-to-back writes run one per cycle.
  - Unmapped write: silently dropped.
  - h_read and h_write high together: the read is serviced and the write is dropped.
- In RD_WAIT:
  - Timer increments every cycle.
  - s_readdatavalid[sel] = 1: on the next cycle h_readdata = s_readdata[sel] and h_readdatavalid = 1; go to IDLE.
  - No response when timer == TIMEOUT_CYCLES-1: on the next cycle h_readdata = BADADDR_DATA and h_readdatavalid = 1; set timeout_err; go to IDLE.
  - Valid response and timeout in the same cycle: slave data wins, timeout_err is not set.
- Stray response: any s_readdatavalid[j] with j != sel, or any s_readdatavalid outside RD_WAIT (including a late response after timeout), is discarded and sets stray_err.
- s_address slices not selected hold their last value. s_read and s_write are never high on more than one slave at a time.
- Timer width: $clog2(TIMEOUT_CYCLES+1). It never wraps, because the exit happens at TIMEOUT_CYCLES-1.

## Timing
- Reset values (asynchronous, applied immediately):
  - state = IDLE; h_readdata = 0; h_readdatavalid = 0.
  - s_read = 0; s_write = 0; s_address = 0; s_writedata = 0; s_byteenable = 0.
  - timeout_err = 0; stray_err = 0.
  - h_waitrequest = 1 while reset is high.
- Reset mid-read: the transaction is abandoned and no host response is issued. A slave response arriving after reset deassertion sets stray_err.
- Read latency with a slave responding one cycle after s_read:
  - Host read accepted at cycle N.
  - s_read at N+1.
  - s_readdatavalid at N+2.
  - h_readdatavalid at N+3.
  - A next request is accepted at N+3.
- Unmapped read: accepted at N, h_readdatavalid at N+2.
- Timeout: s_read at N+1, BADADDR response at N+1+TIMEOUT_CYCLES.
- Write: accepted at N, s_write at N+1. There is no host response.
- Sticky flags clear only on reset.

## Test plan
- Read slave 2, offset 0x28, slave returns 64'h1234 one cycle after s_read -> s_read = 4'b0100 at N+1; h_readdatavalid with 64'h1234 at N+3; both flags remain 0.
- Write 64'hA5A5 to 0x3008 then read 0x3008 back-to-back -> s_write[3] at N+1 with offset 0x008; read stalls correctly; returned data matches the slave model.
- Read 0x5000 with N_SLAVES = 4 -> no s_read pulse; h_readdata = BADADDR_DATA at N+2. Write to 0x5000 -> no s_write pulse.
- Slave 1 silent -> BADADDR_DATA exactly TIMEOUT_CYCLES cycles after s_read and timeout_err = 1. A later s_readdatavalid[1] sets stray_err and produces no host strobe.
- Slave responds exactly on the timeout cycle -> slave data is returned and timeout_err stays 0.
- Reset asserted during RD_WAIT -> outputs clear immediately; no h_readdatavalid after release; the next read completes normally.

Source files
------------

// File: rtl/dfh_mmio_router.sv
// dfh_mmio_router
// Fans the host MMIO Avalon-MM port out to a row of DFH CSR slaves. Each slave
// owns one 2**SLAVE_SPAN_LOG2-byte window. Reads and writes are forwarded as
// registered single-cycle pulses. Only one read may be outstanding at a time.
// Unmapped reads and reads that time out are answered with BADADDR_DATA, so
// the host never hangs.
//
// Ports:
//   clk_i, reset_i          clock, asynchronous active-high reset
//   h_*_i / h_*_o           host Avalon-MM slave side (64-bit data)
//   s_*_o / s_*_i           per-slave Avalon-MM master side. Address, read,
//                           write, readdata and readdatavalid are sliced per
//                           slave; writedata and byteenable are shared.
//   timeout_err_o           sticky: a read timed out
//   stray_err_o             sticky: an unexpected s_readdatavalid arrived
module dfh_mmio_router #(
  parameter int          N_SLAVES        = 4,
  parameter int          SLAVE_SPAN_LOG2 = 12,
  parameter int          ADDR_WIDTH      = 16,
  parameter int          TIMEOUT_CYCLES  = 256,
  parameter logic [63:0] BADADDR_DATA    = 64'hBAAD_BAAD_BAAD_BAAD
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [ADDR_WIDTH-1:0]               h_address_i,
  input  logic                                h_read_i,
  input  logic                                h_write_i,
  input  logic [63:0]                         h_writedata_i,
  input  logic [7:0]                          h_byteenable_i,
  output logic                                h_waitrequest_o,
  output logic [63:0]                         h_readdata_o,
  output logic                                h_readdatavalid_o,
  output logic [N_SLAVES*SLAVE_SPAN_LOG2-1:0] s_address_o,
  output logic [N_SLAVES-1:0]                 s_read_o,
  output logic [N_SLAVES-1:0]                 s_write_o,
  output logic [63:0]                         s_writedata_o,
  output logic [7:0]                          s_byteenable_o,
  input  logic [N_SLAVES*64-1:0]              s_readdata_i,
  input  logic [N_SLAVES-1:0]                 s_readdatavalid_i,
  output logic                                timeout_err_o,
  output logic                                stray_err_o
);

  localparam int IDX_W = ADDR_WIDTH - SLAVE_SPAN_LOG2;
  localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST     = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W:0]   N_SLAVES_EXT = (IDX_W + 1)'(N_SLAVES);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BAD} state_t;

  state_t                              state_q, state_d;
  logic [SEL_W-1:0]                    sel_q, sel_d;
  logic [TMR_W-1:0]                    timer_q, timer_d;
  logic [63:0]                         h_rdata_q, h_rdata_d;
  logic                                h_rdv_q, h_rdv_d;
  logic [N_SLAVES-1:0]                 s_read_q, s_read_d;
  logic [N_SLAVES-1:0]                 s_write_q, s_write_d;
  logic [N_SLAVES*SLAVE_SPAN_LOG2-1:0] s_addr_q, s_addr_d;
  logic [63:0]                         s_wdata_q, s_wdata_d;
  logic [7:0]                          s_be_q, s_be_d;
  logic                                timeout_err_q, timeout_err_d;
  logic                                stray_err_q, stray_err_d;

  // Address decode
  logic [IDX_W-1:0]           idx;
  logic [SEL_W-1:0]           idx_sel;
  logic [SLAVE_SPAN_LOG2-1:0] offset;
  logic                       mapped;

  assign idx     = h_address_i[ADDR_WIDTH-1:SLAVE_SPAN_LOG2];
  assign idx_sel = idx[SEL_W-1:0];
  assign offset  = h_address_i[SLAVE_SPAN_LOG2-1:0];
  // Zero-extend so that the compare also works when IDX_W bits cannot hold N_SLAVES.
  assign mapped  = ({1'b0, idx} < N_SLAVES_EXT);

  // Only the selected slave may respond, and only while its read is
  // outstanding. Any other strobe is a stray, including a late response after
  // a timeout or after a reset.
  logic [N_SLAVES-1:0] rsp_expect;
  logic [N_SLAVES-1:0] stray;

  always_comb begin
    rsp_expect = '0;
    if (state_q == RD_WAIT) rsp_expect[sel_q] = 1'b1;
    stray = s_readdatavalid_i & ~rsp_expect;
  end

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    timer_d       = timer_q;
    h_rdata_d     = h_rdata_q;
    h_rdv_d       = 1'b0;
    s_read_d      = '0;
    s_write_d     = '0;
    s_addr_d      = s_addr_q;
    s_wdata_d     = s_wdata_q;
    s_be_d        = s_be_q;
    timeout_err_d = timeout_err_q;
    stray_err_d   = stray_err_q | (|stray);

    case (state_q)
      IDLE: begin
        // A read takes priority, so a simultaneous write is dropped.
        if (h_read_i) begin
          if (mapped) begin
            sel_d             = idx_sel;
            s_read_d[idx_sel] = 1'b1;
            s_addr_d[idx_sel*SLAVE_SPAN_LOG2 +: SLAVE_SPAN_LOG2] = offset;
            timer_d           = '0;
            state_d           = RD_WAIT;
          end else begin
            state_d = RD_BAD;
          end
        end else if (h_write_i && mapped) begin
          s_write_d[idx_sel] = 1'b1;
          s_addr_d[idx_sel*SLAVE_SPAN_LOG2 +: SLAVE_SPAN_LOG2] = offset;
          s_wdata_d          = h_writedata_i;
          s_be_d             = h_byteenable_i;
        end
      end
      RD_BAD: begin
        h_rdv_d   = 1'b1;
        h_rdata_d = BADADDR_DATA;
        state_d   = IDLE;
      end
      RD_WAIT: begin
        timer_d = timer_q + 1'b1;
        // The slave response is checked first, so a response on the last
        // timer cycle wins over the timeout.
        if (s_readdatavalid_i[sel_q]) begin
          h_rdv_d   = 1'b1;
          h_rdata_d = s_readdata_i[sel_q*64 +: 64];
          state_d   = IDLE;
        end else if (timer_q == TMR_LAST) begin
          h_rdv_d       = 1'b1;
          h_rdata_d     = BADADDR_DATA;
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      timer_q       <= '0;
      h_rdata_q     <= '0;
      h_rdv_q       <= 1'b0;
      s_read_q      <= '0;
      s_write_q     <= '0;
      s_addr_q      <= '0;
      s_wdata_q     <= '0;
      s_be_q        <= '0;
      timeout_err_q <= 1'b0;
      stray_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      timer_q       <= timer_d;
      h_rdata_q     <= h_rdata_d;
      h_rdv_q       <= h_rdv_d;
      s_read_q      <= s_read_d;
      s_write_q     <= s_write_d;
      s_addr_q      <= s_addr_d;
      s_wdata_q     <= s_wdata_d;
      s_be_q        <= s_be_d;
      timeout_err_q <= timeout_err_d;
      stray_err_q   <= stray_err_d;
    end
  end

  assign h_waitrequest_o   = reset_i | (state_q != IDLE);
  assign h_readdata_o      = h_rdata_q;
  assign h_readdatavalid_o = h_rdv_q;
  assign s_address_o       = s_addr_q;
  assign s_read_o          = s_read_q;
  assign s_write_o         = s_write_q;
  assign s_writedata_o     = s_wdata_q;
  assign s_byteenable_o    = s_be_q;
  assign timeout_err_o     = timeout_err_q;
  assign stray_err_o       = stray_err_q;

endmodule

// File: tb/tb_dfh_mmio_router.sv
module tb_dfh_mmio_router;
  localparam int T = 16;
  localparam logic [63:0] BAD = 64'hBAAD_BAAD_BAAD_BAAD;

  logic         clk = 1'b0;
  logic         reset_i;
  logic [15:0]  h_address;
  logic         h_read, h_write;
  logic [63:0]  h_writedata;
  logic [7:0]   h_byteenable;
  logic         h_waitrequest;
  logic [63:0]  h_readdata;
  logic         h_readdatavalid;
  logic [47:0]  s_address;
  logic [3:0]   s_read, s_write;
  logic [63:0]  s_writedata;
  logic [7:0]   s_byteenable;
  logic [255:0] s_readdata;
  logic [3:0]   s_readdatavalid;
  logic         timeout_err, stray_err;

  dfh_mmio_router #(.N_SLAVES(4), .SLAVE_SPAN_LOG2(12), .ADDR_WIDTH(16),
                    .TIMEOUT_CYCLES(T), .BADADDR_DATA(BAD)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .h_address_i(h_address), .h_read_i(h_read), .h_write_i(h_write),
    .h_writedata_i(h_writedata), .h_byteenable_i(h_byteenable),
    .h_waitrequest_o(h_waitrequest), .h_readdata_o(h_readdata),
    .h_readdatavalid_o(h_readdatavalid),
    .s_address_o(s_address), .s_read_o(s_read), .s_write_o(s_write),
    .s_writedata_o(s_writedata), .s_byteenable_o(s_byteenable),
    .s_readdata_i(s_readdata), .s_readdatavalid_i(s_readdatavalid),
    .timeout_err_o(timeout_err), .stray_err_o(stray_err)
  );

  always #5 clk = ~clk;

  int ecnt = 0;                     // number of rising edges seen
  always @(posedge clk) ecnt <= ecnt + 1;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct { logic [63:0] data; int cyc; } hexp_t;
  typedef struct { bit wr; int idx; logic [11:0] off; logic [63:0] wd; logic [7:0] be; int cyc; } sexp_t;
  hexp_t hq[$];
  sexp_t sq[$];

  // Slave model: delay[i] = edges from s_read sample to s_readdatavalid sample, 0 = silent
  logic [63:0] mem [4][512];
  int          delay [4];
  int          due [4];
  logic [63:0] rd_hold [4];
  bit          inj [4];
  int          ncnt = 0;

  initial begin
    s_readdatavalid = '0;
    s_readdata      = '0;
    for (int i = 0; i < 4; i++) begin due[i] = -1; inj[i] = 1'b0; delay[i] = 1; end
    forever begin
      @(negedge clk);
      ncnt++;
      for (int i = 0; i < 4; i++) begin
        s_readdatavalid[i] = (due[i] == ncnt) | inj[i];
        if (due[i] == ncnt) s_readdata[i*64 +: 64] = rd_hold[i];
        inj[i] = 1'b0;
        if (s_write[i])
          for (int b = 0; b < 8; b++)
            if (s_byteenable[b]) mem[i][s_address[i*12+3 +: 9]][b*8 +: 8] = s_writedata[b*8 +: 8];
        if (s_read[i] && delay[i] != 0) begin
          due[i]     = ncnt + delay[i];
          rd_hold[i] = mem[i][s_address[i*12+3 +: 9]];
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a host response or slave pulse
  initial begin
    hexp_t he;
    sexp_t se;
    logic [3:0] oh;
    forever begin
      @(negedge clk);
      if (h_readdatavalid) begin
        n_cmp++;
        if (hq.size() == 0) begin
          n_fail++;
          $display("FAIL host_rsp unexpected at edge %0d: got data=%h, required no response", ecnt, h_readdata);
        end else begin
          he = hq.pop_front();
          if (h_readdata !== he.data || ecnt != he.cyc) begin
            n_fail++;
            $display("FAIL host_rsp: got data=%h edge=%0d, required data=%h edge=%0d",
                     h_readdata, ecnt, he.data, he.cyc);
          end else
            $display("host_rsp ok data=%h edge=%0d", h_readdata, ecnt);
        end
      end
      if (s_read != 4'b0 || s_write != 4'b0) begin
        n_cmp++;
        if (sq.size() == 0) begin
          n_fail++;
          $display("FAIL slave_req unexpected at edge %0d: got rd=%b wr=%b, required none", ecnt, s_read, s_write);
        end else begin
          se = sq.pop_front();
          oh = 4'b0001 << se.idx;
          if (s_read !== (se.wr ? 4'b0 : oh) || s_write !== (se.wr ? oh : 4'b0) ||
              s_address[se.idx*12 +: 12] !== se.off || ecnt != se.cyc ||
              (se.wr && (s_writedata !== se.wd || s_byteenable !== se.be))) begin
            n_fail++;
            $display("FAIL slave_req: got rd=%b wr=%b off=%h wd=%h be=%h edge=%0d, required wr=%0d sel=%b off=%h wd=%h be=%h edge=%0d",
                     s_read, s_write, s_address[se.idx*12 +: 12], s_writedata, s_byteenable, ecnt,
                     se.wr, oh, se.off, se.wd, se.be, se.cyc);
          end else
            $display("slave_req ok wr=%0d sel=%b off=%h edge=%0d", se.wr, oh, se.off, ecnt);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end else
      $display("check %s ok = %h", name, act);
  endtask

  // Called at a negedge with request already driven; returns accept edge number.
  task automatic wait_accept(output int n);
    int g = 0;
    while (h_waitrequest && g < 500) begin @(negedge clk); g++; end
    if (g >= 500) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: waitrequest still %b, required 0", h_waitrequest);
    end
    n = ecnt + 1;
  endtask

  task automatic host_read(input logic [15:0] a, input logic [63:0] d, input int lat,
                           input bit mapped, input bit expect_rsp);
    int n;
    hexp_t he;
    sexp_t se;
    h_address = a; h_read = 1'b1;
    wait_accept(n);
    if (expect_rsp) begin he.data = d; he.cyc = n + lat; hq.push_back(he); end
    if (mapped) begin
      se.wr = 1'b0; se.idx = int'(a[15:12]); se.off = a[11:0]; se.wd = '0; se.be = '0; se.cyc = n;
      sq.push_back(se);
    end
    @(negedge clk);
    h_read = 1'b0;
  endtask

  task automatic host_write(input logic [15:0] a, input logic [63:0] d, input logic [7:0] be,
                            input bit mapped);
    int n;
    sexp_t se;
    h_address = a; h_write = 1'b1; h_writedata = d; h_byteenable = be;
    wait_accept(n);
    if (mapped) begin
      se.wr = 1'b1; se.idx = int'(a[15:12]); se.off = a[11:0]; se.wd = d; se.be = be; se.cyc = n;
      sq.push_back(se);
    end
    @(negedge clk);
    h_write = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((hq.size() != 0 || sq.size() != 0) && g < 500) begin @(negedge clk); g++; end
    @(negedge clk);
    if (g >= 500) begin
      n_cmp++; n_fail++;
      $display("FAIL response_timeout: %0d host / %0d slave expectations pending, required 0", hq.size(), sq.size());
      hq.delete(); sq.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++)
      for (int w = 0; w < 512; w++) mem[i][w] = 64'h0;
    mem[2][5] = 64'h1234;
    mem[3][2] = 64'hFFFF_FFFF_FFFF_FFFF;
    mem[0][0] = 64'hC0DE;
    reset_i = 1'b1; h_address = '0; h_read = 1'b0; h_write = 1'b0;
    h_writedata = '0; h_byteenable = '0;
    repeat (3) @(negedge clk);
    chk("rst_waitrequest", 64'(h_waitrequest), 64'd1);
    chk("rst_readdatavalid", 64'(h_readdatavalid), 64'd0);
    chk("rst_readdata", h_readdata, 64'd0);
    chk("rst_s_rd_wr", {56'd0, s_read, s_write}, 64'd0);
    chk("rst_s_address", 64'(s_address), 64'd0);
    chk("rst_flags", {62'd0, timeout_err, stray_err}, 64'd0);
    reset_i = 1'b0;
    @(negedge clk);
    chk("idle_waitrequest", 64'(h_waitrequest), 64'd0);

    // Read slave 2 offset 0x28, one-cycle slave
    delay[2] = 1;
    host_read(16'h2028, 64'h1234, 2, 1, 1);
    wait_idle();
    chk("flags_after_read", {62'd0, timeout_err, stray_err}, 64'd0);

    // Write then read back-to-back, partial byte enables, back-to-back writes
    delay[3] = 2; delay[0] = 1; delay[1] = 1;
    host_write(16'h3008, 64'hA5A5, 8'hFF, 1);
    host_read(16'h3008, 64'hA5A5, 3, 1, 1);
    host_write(16'h3010, 64'h1111_2222_3333_4444, 8'h0F, 1);
    host_read(16'h3010, 64'hFFFF_FFFF_3333_4444, 3, 1, 1);
    host_write(16'h0008, 64'hDEAD_0001, 8'hFF, 1);
    host_write(16'h1008, 64'hBEEF_0002, 8'hFF, 1);
    host_write(16'h5000, 64'h9999, 8'hFF, 0);
    host_read(16'h0008, 64'hDEAD_0001, 2, 1, 1);
    host_read(16'h1008, 64'hBEEF_0002, 2, 1, 1);
    // Read plus write together: the read wins, the write is dropped
    h_write = 1'b1; h_writedata = 64'h7777; h_byteenable = 8'hFF;
    host_read(16'h1008, 64'hBEEF_0002, 2, 1, 1);
    h_write = 1'b0;
    wait_idle();

    // Unmapped accesses
    host_read(16'h5000, BAD, 1, 0, 1);
    host_write(16'h5000, 64'h1, 8'hFF, 0);
    host_read(16'hF008, BAD, 1, 0, 1);
    wait_idle();

    // Response on exactly the timeout cycle: slave wins
    delay[0] = T - 1;
    host_read(16'h0000, 64'hC0DE, T, 1, 1);
    wait_idle();
    chk("timeout_edge_no_err", 64'(timeout_err), 64'd0);

    // Silent slave 1: timeout, then a late stray response
    delay[1] = 0;
    host_read(16'h1010, BAD, T, 1, 1);
    wait_idle();
    chk("timeout_err_set", 64'(timeout_err), 64'd1);
    chk("stray_before_late", 64'(stray_err), 64'd0);
    inj[1] = 1'b1;
    repeat (3) @(negedge clk);
    chk("stray_after_late", 64'(stray_err), 64'd1);

    // Reset during RD_WAIT
    delay[3] = 6;
    host_read(16'h3008, 64'h0, 0, 1, 0);
    @(negedge clk);
    reset_i = 1'b1;
    #1;
    chk("midrst_waitrequest", 64'(h_waitrequest), 64'd1);
    chk("midrst_flags", {62'd0, timeout_err, stray_err}, 64'd0);
    chk("midrst_outputs", {55'd0, h_readdatavalid, s_read, s_write}, 64'd0);
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    chk("postrst_waitrequest", 64'(h_waitrequest), 64'd0);
    repeat (6) @(negedge clk);
    chk("postrst_stray", 64'(stray_err), 64'd1);
    delay[3] = 1;
    host_read(16'h3008, 64'hA5A5, 2, 1, 1);
    wait_idle();
    chk("postrst_timeout_err", 64'(timeout_err), 64'd0);
    repeat (3) @(negedge clk);
    chk("queues_empty", 64'(hq.size() + sq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
